// File: rtl/weight_pkg.sv
// Shared types and helpers for the weight_bank memory: FSM states, LFSR tap
// masks for widths 4..32 and the lane-address wrap used by burst accesses.
package weight_pkg;

   typedef enum logic {ST_INIT, ST_IDLE} state_e;

   // Maximal-length Fibonacci tap masks, indexed by LFSR width
   localparam logic [31:0] TAPS [4:32] = '{
      32'h0000000C, 32'h00000014, 32'h00000030, 32'h00000060,
      32'h000000B8, 32'h00000110, 32'h00000240, 32'h00000500,
      32'h00000829, 32'h0000100D, 32'h00002015, 32'h00006000,
      32'h0000D008, 32'h00012000, 32'h00020400, 32'h00040023,
      32'h00090000, 32'h00140000, 32'h00300000, 32'h00420000,
      32'h00E10000, 32'h01200000, 32'h02000023, 32'h04000013,
      32'h09000000, 32'h14000000, 32'h20000029, 32'h48000000,
      32'h80200003
   };

   function automatic int wrap_idx(input int base, input int lane, input int depth);
      return ((base % depth) + lane) % depth;
   endfunction

endpackage

// File: rtl/weight_lfsr.sv
// Fibonacci LFSR that supplies the initial weights during a refill; Load
// restarts it from SEED and Step advances it by one position.
module weight_lfsr
   import weight_pkg::*;
#(
   parameter int             W    = 10,
   parameter logic [W-1:0]   SEED = 1
) (
   input  logic         Clock,
   input  logic         Rst,
   input  logic         Load,
   input  logic         Step,
   output logic [W-1:0] Value
);

   localparam logic [W-1:0] MASK = W'(TAPS[W]);

   logic [W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (Load)
         value_d = SEED;
      else if (Step)
         value_d = {value_q[W-2:0], ^(value_q & MASK)};
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst)
         value_q <= SEED;
      else
         value_q <= value_d;
   end

   assign Value = value_q;

endmodule

// File: rtl/weight_bank.sv
// Multi-lane weight memory with N-lane burst read/write; the LFSR refill and
// the Init port exist only when WEIGHT_BANK_LFSR_INIT_EN is defined.
//
//   state   | meaning
//   ST_INIT | writing mem[k] = lfsr, one word per cycle; Ready low
//   ST_IDLE | serving accesses; Init starts a new refill
module weight_bank
   import weight_pkg::*;
#(
   parameter int  N     = 10,
   parameter int  W     = 10,
   parameter int  DEPTH = 65,
   parameter int  SEED  = 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic           Clock,
   input  logic           Rst,
   input  logic           Init,
   input  logic           Req,
   input  logic           WE,
   input  logic [AW-1:0]  Address,
   input  logic [N*W-1:0] D,
   output logic           Ready,
   output logic [N*W-1:0] Q,
   output logic           QValid,
   output logic           Busy,
   output logic           InitDone
);

   logic [W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]  lane_idx [N];
   logic [N*W-1:0] q_q, q_d;
   logic           qvalid_q, qvalid_d;
   logic           acc_wr, acc_rd;

   always_comb begin
      for (int i = 0; i < N; i++)
         lane_idx[i] = AW'(wrap_idx(int'(Address), i, DEPTH));
   end

`ifdef WEIGHT_BANK_LFSR_INIT_EN
   state_e        state_q, state_d;
   logic [AW-1:0] k_q, k_d;
   logic [W-1:0]  lfsr_val;
   logic          lfsr_load, lfsr_step;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state_q)
         ST_INIT: begin
            lfsr_step = 1'b1;
            if (k_q == AW'(DEPTH-1)) begin
               k_d     = '0;
               state_d = ST_IDLE;
            end else begin
               k_d = k_q + AW'(1);
            end
         end
         ST_IDLE: begin
            if (Init) begin
               state_d   = ST_INIT;
               k_d       = '0;
               lfsr_load = 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state_q <= ST_INIT;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   weight_lfsr #(.W(W), .SEED(W'(SEED))) u_lfsr (
      .Clock (Clock),
      .Rst   (Rst),
      .Load  (lfsr_load),
      .Step  (lfsr_step),
      .Value (lfsr_val)
   );

   assign Ready    = (state_q == ST_IDLE) && !Init;
   assign Busy     = (state_q == ST_INIT);
   assign InitDone = (state_q == ST_INIT) && (k_q == AW'(DEPTH-1));
`else
   logic unused_init;
   assign unused_init = Init;
   assign Ready       = 1'b1;
   assign Busy        = 1'b0;
   assign InitDone    = 1'b0;
`endif

   assign acc_wr = Req && Ready && WE;
   assign acc_rd = Req && Ready && !WE;

   // Memory is deliberately outside the reset domain so Rst keeps its contents
   always_ff @(posedge Clock) begin
`ifdef WEIGHT_BANK_LFSR_INIT_EN
      if (state_q == ST_INIT)
         mem_q[k_q] <= lfsr_val;
      else
`endif
      if (acc_wr) begin
         for (int i = 0; i < N; i++)
            mem_q[lane_idx[i]] <= D[i*W +: W];
      end
   end

   always_comb begin
      q_d      = q_q;
      qvalid_d = acc_rd;
      if (acc_rd) begin
         for (int i = 0; i < N; i++)
            q_d[i*W +: W] = mem_q[lane_idx[i]];
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         q_q      <= '0;
         qvalid_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         qvalid_q <= qvalid_d;
      end
   end

   assign Q      = q_q;
   assign QValid = qvalid_q;

endmodule

// File: tb/tb_weight_bank.sv
// Directed self-checking bench for weight_bank (N=4, W=10, DEPTH=65, SEED=1);
// refill checks are compiled in only with WEIGHT_BANK_LFSR_INIT_EN.
module tb_weight_bank;

   localparam int N = 4;
   localparam int W = 10;
   localparam int DEPTH = 65;
   localparam int AW = 7;

`ifdef WEIGHT_BANK_LFSR_INIT_EN
   localparam logic BUSY_RST  = 1'b1;
   localparam logic READY_RST = 1'b0;
`else
   localparam logic BUSY_RST  = 1'b0;
   localparam logic READY_RST = 1'b1;
`endif

   logic           Clock, Rst, Init, Req, WE;
   logic [AW-1:0]  Address;
   logic [N*W-1:0] D;
   logic           Ready, QValid, Busy, InitDone;
   logic [N*W-1:0] Q;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_mem  [DEPTH];
   logic [W-1:0] lfsr_exp [DEPTH];

   weight_bank #(.N(N), .W(W), .DEPTH(DEPTH), .SEED(1)) dut (
      .Clock    (Clock),
      .Rst      (Rst),
      .Init     (Init),
      .Req      (Req),
      .WE       (WE),
      .Address  (Address),
      .D        (D),
      .Ready    (Ready),
      .Q        (Q),
      .QValid   (QValid),
      .Busy     (Busy),
      .InitDone (InitDone)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*W-1:0] pack(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                           input logic [W-1:0] l2, input logic [W-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [N*W-1:0] exp_q(input int addr);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++)
         r[i*W +: W] = exp_mem[((addr % DEPTH) + i) % DEPTH];
      return r;
   endfunction

   task automatic do_write(input int addr, input logic [N*W-1:0] data);
      Address = AW'(addr);
      D = data;
      Req = 1'b1;
      WE = 1'b1;
      step();
      Req = 1'b0;
      WE = 1'b0;
      for (int i = 0; i < N; i++)
         exp_mem[((addr % DEPTH) + i) % DEPTH] = data[i*W +: W];
   endtask

   task automatic do_read(input int addr);
      Address = AW'(addr);
      Req = 1'b1;
      WE = 1'b0;
      step();
      Req = 1'b0;
   endtask

   task automatic run_refill(output int len, output int done_at, output int done_cnt);
      len = 0;
      done_at = -1;
      done_cnt = 0;
      for (int c = 0; c < 200 && Busy; c++) begin
         len++;
         if (InitDone) begin
            done_cnt++;
            done_at = len;
         end
         step();
      end
   endtask

   initial begin
      int len, done_at, done_cnt;
      logic [W-1:0] v;

      Rst = 1'b0; Init = 1'b0; Req = 1'b0; WE = 1'b0; Address = '0; D = '0;
      v = 10'h001;
      for (int k = 0; k < DEPTH; k++) begin
         lfsr_exp[k] = v;
         v = {v[8:0], v[9] ^ v[6]};
      end

      repeat (3) step();
      check("rst_q", 64'(Q), 64'd0);
      check("rst_qvalid", 64'(QValid), 64'd0);
      check("rst_busy", 64'(Busy), 64'(BUSY_RST));
      check("rst_initdone", 64'(InitDone), 64'd0);
      check("rst_ready", 64'(Ready), 64'(READY_RST));
      Rst = 1'b1;

`ifdef WEIGHT_BANK_LFSR_INIT_EN
      run_refill(len, done_at, done_cnt);
      check("refill_len", 64'(len), 64'd65);
      check("initdone_at", 64'(done_at), 64'd65);
      check("initdone_cnt", 64'(done_cnt), 64'd1);
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = lfsr_exp[k];
      check("ready_idle", 64'(Ready), 64'd1);
      do_read(0);
      check("first4_q", 64'(Q), 64'(pack(10'h001, 10'h002, 10'h004, 10'h008)));
      check("first4_v", 64'(QValid), 64'd1);
`endif

      do_write(10, pack(10'd1, 10'd2, 10'd3, 10'd4));
      check("wr_no_qvalid", 64'(QValid), 64'd0);
      do_read(10);
      check("rd10_q", 64'(Q), 64'(pack(10'd1, 10'd2, 10'd3, 10'd4)));
      check("rd10_v", 64'(QValid), 64'd1);
      step();
      check("q_hold", 64'(Q), 64'(pack(10'd1, 10'd2, 10'd3, 10'd4)));
      check("qvalid_pulse", 64'(QValid), 64'd0);

      do_write(63, pack(10'd5, 10'd6, 10'd7, 10'd8));
      do_read(63);
      check("wrap_rd63", 64'(Q), 64'(pack(10'd5, 10'd6, 10'd7, 10'd8)));
      do_read(0);
      check("wrap_w0", 64'(Q[9:0]), 64'd7);
      check("wrap_w1", 64'(Q[19:10]), 64'd8);
      do_read(75);
      check("addr_mod", 64'(Q), 64'(pack(10'd1, 10'd2, 10'd3, 10'd4)));

      Req = 1'b1;
      WE = 1'b1;
      for (int i = 0; i < 8; i++) begin
         Address = AW'(i * 4);
         for (int l = 0; l < N; l++) begin
            D[l*W +: W] = W'((i * 4 + l) * 37 + 11);
            exp_mem[i * 4 + l] = W'((i * 4 + l) * 37 + 11);
         end
         step();
      end
      WE = 1'b0;
      Address = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("b2b_v", 64'(QValid), 64'd1);
         check("b2b_q", 64'(Q), 64'(exp_q(i * 4)));
         if (i < 7) Address = AW'((i + 1) * 4);
         else Req = 1'b0;
      end
      step();
      check("b2b_end_v", 64'(QValid), 64'd0);
      do_read(4);
      check("b2b_word5", 64'(Q[19:10]), 64'd196);

`ifdef WEIGHT_BANK_LFSR_INIT_EN
      Init = 1'b1; Req = 1'b1; WE = 1'b1; Address = AW'(20);
      D = pack(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
      #1;
      check("init_beats_req", 64'(Ready), 64'd0);
      step();
      Init = 1'b0; Req = 1'b0; WE = 1'b0;
      run_refill(len, done_at, done_cnt);
      check("reinit_len", 64'(len), 64'd65);
      check("reinit_done_at", 64'(done_at), 64'd65);
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = lfsr_exp[k];
      do_read(20);
      check("reinit_w20", 64'(Q), 64'(pack(lfsr_exp[20], lfsr_exp[21], lfsr_exp[22], lfsr_exp[23])));
      do_read(0);
      check("reinit_w0", 64'(Q), 64'(pack(10'h001, 10'h002, 10'h004, 10'h008)));

      Init = 1'b1;
      step();
      Init = 1'b0;
      repeat (30) step();
      Rst = 1'b0;
      #1;
      check("midrst_q", 64'(Q), 64'd0);
      check("midrst_qvalid", 64'(QValid), 64'd0);
      check("midrst_busy", 64'(Busy), 64'd1);
      check("midrst_ready", 64'(Ready), 64'd0);
      step();
      Rst = 1'b1;
      run_refill(len, done_at, done_cnt);
      check("midrst_len", 64'(len), 64'd65);
      check("midrst_done_at", 64'(done_at), 64'd65);
      do_read(40);
      check("midrst_w40", 64'(Q), 64'(pack(lfsr_exp[40], lfsr_exp[41], lfsr_exp[42], lfsr_exp[43])));
      do_read(62);
      check("midrst_w62", 64'(Q), 64'(pack(lfsr_exp[62], lfsr_exp[63], lfsr_exp[64], lfsr_exp[0])));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
